movz_movk_encoder: RTL and testbench
====================================

Name: movz_movk_encoder

Overview:
- Instruction-word encoder, the inverse of the wide-move decoders: takes a 64-bit constant and a destination register and emits a stream of 32-bit MOVZ/MOVK instruction words that rebuild the constant in Xd.
- Used by the bootloader/test-program path that fills instruction memory.
- Valid/ready handshake on input and output; one instruction word per accepted output beat.

Parameters:
- SKIP_ZERO, 1, 1: omit MOVK for 0x0000 halfwords; 0: always emit MOVZ hw0 followed by MOVK hw1..hw3 (4 words).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept a request
- in_value  input  64  constant to materialise
- in_rd  input  5  destination register Rd
- out_valid  output  1  out_instr valid
- out_ready  input  1  consumer accepts word
- out_instr  output  32  encoded instruction {op[8:0], hw[1:0], imm16, Rd}
- out_last  output  1  final word of current sequence
- busy  output  1  sequence in progress

Behaviour:
- Encodings: MOVZ op = 9'b110100101, MOVK op = 9'b111100101, MOVN op = 9'b100100101 (macro only). Field layout is [31:23] op, [22:21] hw, [20:5] imm16, [4:0] Rd.
- States: IDLE, EMIT. in_ready = (state==IDLE). busy = (state==EMIT).
- Reset values: state IDLE, out_valid 0, out_instr 0, out_last 0, in_ready 1, busy 0. All outputs are registered except in_ready and busy, which decode the registered state.
- IDLE transition: when in_valid && in_ready at edge t, latch value and Rd, then compute the 4-bit pending mask (bit i = halfword i != 0, or all ones if SKIP_ZERO=0).
- First word is presented at t+1 (latency 1), state EMIT:
  - It is MOVZ with hw = lowest set bit of the mask, imm = that halfword.
  - If the mask is empty (value 0), emit MOVZ hw0 imm 0.
  - Clear that bit from the mask.
- In EMIT, on out_valid && out_ready:
  - If the mask is empty: the word just taken had out_last=1. Go to IDLE and drop out_valid the next cycle. No new request is accepted in that same edge, so back-to-back sequences have a 1-cycle bubble.
  - Otherwise: load the next word, MOVK for the lowest remaining set bit, ascending hw. Clear that bit and set out_last if the mask becomes empty.
- out_last is set whenever the presented word is the final one.
- Backpressure: while out_valid && !out_ready, out_instr and out_last hold stable and the mask does not change.
- Word count per request is 1..4. Order is always ascending hw, and MOVZ (or MOVN) is always first.
- in_value and in_rd are ignored outside the accept edge.
- Reset mid-sequence: the sequence is abandoned immediately and outputs return to reset values. There is no partial completion.
- in_valid during EMIT is not accepted, because in_ready is 0.

Optional Feature:
- Macro: MOVZ_MOVK_ENCODER_MOVN_OPT_EN.
- With the macro: at accept, count halfwords equal to 0xFFFF (nF) and equal to 0x0000 (nZ). If nF > nZ:
  - First word is MOVN with hw = lowest halfword != 0xFFFF, imm = ~halfword.
  - Then MOVK for each remaining halfword != 0xFFFF.
  - All-ones value emits MOVN hw0 imm 0.
  - SKIP_ZERO applies to 0x0000 halfwords only in MOVZ mode.
- Without the macro: MOVZ/MOVK only, and 0xFFFF halfwords are emitted as MOVK like any non-zero halfword.

Decomposition:
- Shared package (controlunit_pkg) holds:
  - opcode constants OP_MOVZ, OP_MOVK, OP_MOVN (9-bit);
  - field widths (HW_W=2, IMM_W=16, RD_W=5);
  - encoder state enum {IDLE, EMIT}.
- One natural sub-module: wide_move_word_pack, a combinational packer of {op, hw, imm, Rd} into 32 bits. It is reused by other encoders.

Test Plan:
- Single word: value 0x0000_0000_0000_1234, rd 3 → one word 0xD2824683, out_last=1, accepted word at t+1.
- Zero value: value 0, rd 0 → one word 0xD2800000, out_last=1.
- Sparse constant: value 0x1234_0000_5678_0000, rd 1 → 0xD2AACF01 (last=0), then 0xF2E24681 (last=1).
- Backpressure: in the sparse case, hold out_ready=0 for 3 cycles → out_instr stays 0xD2AACF01, in_ready=0, busy=1; the sequence resumes unchanged.
- Reset mid-sequence: assert reset after the first word of a 4-word sequence → out_valid=0, out_instr=0 in the same cycle, in_ready=1 after release; a new request 0x1234, rd 3 yields 0xD2824683.
- MOVN: value 0xFFFF_FFFF_FFFF_EDCB, rd 2.
  - Macro defined → one word 0x92824682.
  - Undefined → 4 words: MOVZ hw0 0xEDCB, then MOVK hw1..3 imm 0xFFFF, last on hw3.

Source files
------------

// File: rtl/controlunit_pkg.sv
// Shared wide-move encoding constants, field widths and encoder state type.
// Helpers select halfwords and find the lowest pending halfword.
package controlunit_pkg;

    localparam int OP_W  = 9;
    localparam int HW_W  = 2;
    localparam int IMM_W = 16;
    localparam int RD_W  = 5;

    localparam logic [OP_W-1:0] OP_MOVZ = 9'b110100101;
    localparam logic [OP_W-1:0] OP_MOVK = 9'b111100101;
    localparam logic [OP_W-1:0] OP_MOVN = 9'b100100101;

    typedef enum logic {
        IDLE,
        EMIT
    } enc_state_t;

    // Index of the lowest set bit; 0 for an empty mask.
    function automatic logic [HW_W-1:0] lowest_set(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else if (m[3]) return 2'd3;
        else           return 2'd0;
    endfunction

    function automatic logic [IMM_W-1:0] halfword(input logic [63:0] v,
                                                  input logic [HW_W-1:0] i);
        case (i)
            2'd0:    return v[15:0];
            2'd1:    return v[31:16];
            2'd2:    return v[47:32];
            default: return v[63:48];
        endcase
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] m);
        return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

endpackage

// File: rtl/wide_move_word_pack.sv
// Combinational packer for wide-move instruction words: {op, hw, imm16, Rd}.
module wide_move_word_pack
    import controlunit_pkg::*;
(
    input  logic [OP_W-1:0]  op_i,
    input  logic [HW_W-1:0]  hw_i,
    input  logic [IMM_W-1:0] imm_i,
    input  logic [RD_W-1:0]  rd_i,
    output logic [31:0]      word_o
);

    assign word_o = {op_i, hw_i, imm_i, rd_i};

endmodule

// File: rtl/movz_movk_encoder.sv
// Turns a 64-bit constant into an ascending-hw MOVZ/MOVK word stream for Xd.
// Optional MOVN-first encoding for mostly-ones constants: MOVZ_MOVK_ENCODER_MOVN_OPT_EN.
module movz_movk_encoder
    import controlunit_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_value,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic              out_last,
    output logic              busy
);

    enc_state_t       state_q, state_d;
    logic             valid_q, valid_d;
    logic [31:0]      instr_q, instr_d;
    logic             last_q,  last_d;
    logic [3:0]       mask_q,  mask_d;
    logic [63:0]      value_q;
    logic [RD_W-1:0]  rd_q;
    logic             load_data;

    logic [3:0]       nz_mask;
    logic [3:0]       acc_mask;
    logic [OP_W-1:0]  acc_op;
    logic             acc_inv;

    logic [3:0]       sel_mask;
    logic [63:0]      sel_value;
    logic [RD_W-1:0]  sel_rd;
    logic [OP_W-1:0]  sel_op;
    logic             sel_inv;
    logic [HW_W-1:0]  sel_hw;
    logic [IMM_W-1:0] sel_imm;
    logic [3:0]       pack_rest;
    logic [31:0]      pack_word;

    for (genvar i = 0; i < 4; i++) begin : g_nz
        assign nz_mask[i] = (in_value[16*i +: 16] != 16'h0000);
    end

`ifdef MOVZ_MOVK_ENCODER_MOVN_OPT_EN
    logic [3:0] ff_mask;
    for (genvar i = 0; i < 4; i++) begin : g_ff
        assign ff_mask[i] = (in_value[16*i +: 16] == 16'hFFFF);
    end
`endif

    // Mode and pending-halfword mask chosen from the incoming constant
    always_comb begin
        acc_mask = SKIP_ZERO ? nz_mask : 4'hF;
        acc_op   = OP_MOVZ;
        acc_inv  = 1'b0;
`ifdef MOVZ_MOVK_ENCODER_MOVN_OPT_EN
        if (popcount4(ff_mask) > popcount4(~nz_mask)) begin
            acc_mask = ~ff_mask;
            acc_op   = OP_MOVN;
            acc_inv  = 1'b1;
        end
`endif
    end

    // In IDLE the packer builds the leading word straight from the request;
    // in EMIT it builds the next MOVK from the latched constant.
    always_comb begin
        if (state_q == IDLE) begin
            sel_mask  = acc_mask;
            sel_value = in_value;
            sel_rd    = in_rd;
            sel_op    = acc_op;
            sel_inv   = acc_inv;
        end else begin
            sel_mask  = mask_q;
            sel_value = value_q;
            sel_rd    = rd_q;
            sel_op    = OP_MOVK;
            sel_inv   = 1'b0;
        end
        sel_hw    = lowest_set(sel_mask);
        sel_imm   = halfword(sel_value, sel_hw) ^ {IMM_W{sel_inv}};
        pack_rest = sel_mask & ~(4'b0001 << sel_hw);
    end

    wide_move_word_pack u_pack (
        .op_i   (sel_op),
        .hw_i   (sel_hw),
        .imm_i  (sel_imm),
        .rd_i   (sel_rd),
        .word_o (pack_word)
    );

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        last_d    = last_q;
        mask_d    = mask_q;
        load_data = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = EMIT;
                    valid_d   = 1'b1;
                    instr_d   = pack_word;
                    mask_d    = pack_rest;
                    last_d    = (pack_rest == 4'b0000);
                    load_data = 1'b1;
                end
            end
            EMIT: begin
                if (valid_q && out_ready) begin
                    if (mask_q == 4'b0000) begin
                        // Final word taken; the return to IDLE costs one bubble
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        instr_d = pack_word;
                        mask_d  = pack_rest;
                        last_d  = (pack_rest == 4'b0000);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            last_q  <= 1'b0;
            mask_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            last_q  <= last_d;
            mask_q  <= mask_d;
        end
    end

    always_ff @(posedge clock) begin
        if (load_data) begin
            value_q <= in_value;
            rd_q    <= in_rd;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == EMIT);
    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_movz_movk_encoder.sv
// Bench for movz_movk_encoder: directed vector table, backpressure and
// mid-sequence reset sequences, then random constants against a word-list model.
module tb_movz_movk_encoder;

    localparam bit SKIP = 1'b1;
    localparam logic [8:0] M_MOVZ = 9'b110100101;
    localparam logic [8:0] M_MOVK = 9'b111100101;
    localparam logic [8:0] M_MOVN = 9'b100100101;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_value;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [63:0] value;
        logic [4:0]  rd;
        int          n;
        logic [31:0] w0, w1, w2, w3;
    } vec_t;

    vec_t vecs[6];

    movz_movk_encoder #(.SKIP_ZERO(SKIP)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] v, input logic [4:0] rd, input int n,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3);
        vec_t r;
        r.value = v; r.rd = rd; r.n = n;
        r.w0 = w0; r.w1 = w1; r.w2 = w2; r.w3 = w3;
        return r;
    endfunction

    // Reference: walk halfwords in ascending order and list the words needed.
    task automatic build_expect(input logic [63:0] v, input logic [4:0] rd);
        int nf = 0;
        int nz = 0;
        bit movn = 1'b0;
        bit first = 1'b1;
        bit emit;
        logic [15:0] h;
        logic [8:0] op;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            h = 16'(v >> (16 * i));
            if (h == 16'hFFFF) nf++;
            if (h == 16'h0000) nz++;
        end
`ifdef MOVZ_MOVK_ENCODER_MOVN_OPT_EN
        movn = (nf > nz);
`endif
        for (int i = 0; i < 4; i++) begin
            h = 16'(v >> (16 * i));
            if (movn) emit = (h != 16'hFFFF);
            else      emit = !SKIP || (h != 16'h0000);
            if (emit) begin
                op = first ? (movn ? M_MOVN : M_MOVZ) : M_MOVK;
                exp_q.push_back({op, 2'(i), (first && movn) ? ~h : h, rd});
                first = 1'b0;
            end
        end
        if (exp_q.size() == 0)
            exp_q.push_back({movn ? M_MOVN : M_MOVZ, 2'b00, 16'h0000, rd});
    endtask

    // mode 0: always ready; 1: stall 3 cycles on the first word; 2: random ready
    task automatic run_seq(input logic [63:0] v, input logic [4:0] rd, input int mode);
        int idx = 0;
        int cyc = 0;
        int stall = 0;
        int n = exp_q.size();
        @(negedge clock);
        in_valid  = 1'b1;
        in_value  = v;
        in_rd     = rd;
        out_ready = 1'b0;
        @(posedge clock); #1;
        // keep in_valid high with junk to show EMIT ignores new requests
        in_value = {$urandom, $urandom};
        in_rd    = 5'($urandom);
        while (idx < n && cyc < 200) begin
            chk("out_valid", out_valid, 1);
            chk("out_instr", out_instr, exp_q[idx]);
            chk("out_last", out_last, (idx == n - 1));
            chk("in_ready_emit", in_ready, 0);
            chk("busy_emit", busy, 1);
            case (mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (idx != 0) || (stall >= 3);
                    if (!out_ready) stall++;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(posedge clock); #1;
            if (out_ready) idx++;
            cyc++;
        end
        if (idx < n) chk("seq_timeout", idx, n);
        chk("done_out_valid", out_valid, 0);
        chk("done_in_ready", in_ready, 1);
        chk("done_busy", busy, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] v;
        logic [15:0] h;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_value  = 64'h0;
        in_rd     = 5'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;

        vecs[0] = mk(64'h0000_0000_0000_1234, 5'd3, 1, 32'hD2824683, 0, 0, 0);
        vecs[1] = mk(64'h0, 5'd0, 1, 32'hD2800000, 0, 0, 0);
        vecs[2] = mk(64'h1234_0000_5678_0000, 5'd1, 2, 32'hD2AACF01, 32'hF2E24681, 0, 0);
`ifdef MOVZ_MOVK_ENCODER_MOVN_OPT_EN
        vecs[3] = mk(64'hFFFF_FFFF_FFFF_EDCB, 5'd2, 1, 32'h92824682, 0, 0, 0);
`else
        vecs[3] = mk(64'hFFFF_FFFF_FFFF_EDCB, 5'd2, 4,
                     32'hD29DB962, 32'hF2BFFFE2, 32'hF2DFFFE2, 32'hF2FFFFE2);
`endif
        vecs[4] = mk(64'h0001_0002_0003_0004, 5'd5, 4,
                     32'hD2800085, 32'hF2A00065, 32'hF2C00045, 32'hF2E00025);
        vecs[5] = mk(64'hABCD_0000_0000_0000, 5'd31, 1, 32'hD2F579BF, 0, 0, 0);

        for (int k = 0; k < 6; k++) begin
            exp_q.delete();
            exp_q.push_back(vecs[k].w0);
            if (vecs[k].n > 1) exp_q.push_back(vecs[k].w1);
            if (vecs[k].n > 2) exp_q.push_back(vecs[k].w2);
            if (vecs[k].n > 3) exp_q.push_back(vecs[k].w3);
            run_seq(vecs[k].value, vecs[k].rd, 0);
        end

        // Backpressure on the first word of the sparse constant
        exp_q.delete();
        exp_q.push_back(32'hD2AACF01);
        exp_q.push_back(32'hF2E24681);
        run_seq(64'h1234_0000_5678_0000, 5'd1, 1);

        // Reset after the first word of a four-word sequence
        @(negedge clock);
        in_valid = 1'b1;
        in_value = 64'h0001_0002_0003_0004;
        in_rd    = 5'd5;
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("mid_first_word", out_instr, 32'hD2800085);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("mid_second_word", out_instr, 32'hF2A00065);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_instr", out_instr, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        exp_q.delete();
        exp_q.push_back(32'hD2824683);
        run_seq(64'h0000_0000_0000_1234, 5'd3, 0);

        // Random constants biased toward 0x0000 / 0xFFFF halfwords
        for (int r = 0; r < 40; r++) begin
            v = 64'h0;
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0:       h = 16'h0000;
                    1:       h = 16'hFFFF;
                    default: h = 16'($urandom);
                endcase
                v = v | (64'(h) << (16 * i));
            end
            in_rd = 5'($urandom);
            build_expect(v, in_rd);
            run_seq(v, in_rd, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
